// File: rtl/school_seating_system.sv
// ---------------------------------------------------------------------------
// school_seating_system
//
// Purpose:
//   Tracks 32 classroom seats. Each seat record holds a student ID, a seat
//   state (FREE / RESERVED / OCCUPIED / AWAY) and, when the auto-release
//   feature is built in, the minute at which the record was last written.
//   A student may hold at most one non-FREE seat. Writes that would break
//   that rule, or that try to claim a seat with the NULL ID, are rejected
//   and flagged on err for one cycle.
//
// Build option:
//   SEAT_AUTO_RELEASE_EN - when defined, RESERVED and AWAY seats whose age
//   reaches TIMEOUT minutes fall back to FREE automatically and release_evt
//   pulses. When undefined, timestamps are not stored and seats only change
//   through writes; release_evt is constant 0.
//
// Parameters:
//   TIMEOUT     - minutes a RESERVED/AWAY seat may persist (1..2047)
//
// Ports:
//   clk         in   1  rising-edge clock
//   reset       in   1  asynchronous, active-high reset
//   Time        in  11  current time in minutes, wraps modulo 2048
//   Student_No  in  25  student ID, all-ones is the NULL ID
//   Seat_No     in   5  seat index, write target and read address
//   write       in   1  write strobe
//   Seat_State  in   2  requested state (00 FREE, 01 RES, 10 OCC, 11 AWAY)
//   rd_student  out 25  stored ID of seat Seat_No (combinational)
//   rd_state    out  2  stored state of seat Seat_No (combinational)
//   free_count  out  6  registered number of FREE seats
//   err         out  1  registered one-cycle pulse for a rejected write
//   release_evt out  1  registered one-cycle pulse after any auto-release
// ---------------------------------------------------------------------------
module school_seating_system #(
  parameter int TIMEOUT = 30
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] Time,
  input  logic [24:0] Student_No,
  input  logic [4:0]  Seat_No,
  input  logic        write,
  input  logic [1:0]  Seat_State,
  output logic [24:0] rd_student,
  output logic [1:0]  rd_state,
  output logic [5:0]  free_count,
  output logic        err,
  output logic        release_evt
);

  localparam logic [1:0]  ST_FREE     = 2'b00;
  localparam logic [1:0]  ST_RESERVED = 2'b01;
  localparam logic [1:0]  ST_OCCUPIED = 2'b10;
  localparam logic [1:0]  ST_AWAY     = 2'b11;
  localparam logic [24:0] NULL_ID     = 25'h1FFFFFF;

  // Committed seat records
  logic [24:0] r_seatId    [32];
  logic [1:0]  r_seatState [32];

  // Next-state view of the records
  logic [24:0] w_nextId    [32];
  logic [1:0]  w_nextState [32];
  logic [5:0]  w_nextFree;

  logic w_dupHit;
  logic w_reject;
  logic w_accept;
  logic w_occupiedUnusedTag;

`ifdef SEAT_AUTO_RELEASE_EN
  localparam logic [10:0] TIMEOUT_MIN = 11'(TIMEOUT);

  logic [10:0] r_seatTs  [32];
  logic [10:0] w_nextTs  [32];
  logic [10:0] w_elapsed [32];
  logic [31:0] w_release;
  logic        r_releaseEvt;
`else
  logic w_unusedBits;
`endif

  // OCCUPIED only matters as "not FREE"; keep the name for readability.
  assign w_occupiedUnusedTag = (Seat_State == ST_OCCUPIED);

  // Zero-latency read port.
  assign rd_student = r_seatId[Seat_No];
  assign rd_state   = r_seatState[Seat_No];

  // One seat per student: look for the requested ID already sitting in some
  // other non-FREE seat. The target seat itself is excluded so a student can
  // change the state of their own seat.
  always_comb begin
    w_dupHit = 1'b0;
    for (int i = 0; i < 32; i++) begin
      if ((5'(i) != Seat_No) && (r_seatState[i] != ST_FREE) &&
          (r_seatId[i] == Student_No)) begin
        w_dupHit = 1'b1;
      end
    end
  end

  // Freeing a seat is always allowed; claiming needs a real, unique ID.
  assign w_reject = write && (Seat_State != ST_FREE) &&
                    ((Student_No == NULL_ID) || w_dupHit);
  assign w_accept = write && !w_reject;

`ifdef SEAT_AUTO_RELEASE_EN
  // Age of every seat in parallel. Modulo-2048 subtraction handles the
  // wrap of the free-running minute counter. A seat that is being written
  // this cycle is not released: the write refreshes it instead.
  always_comb begin
    for (int i = 0; i < 32; i++) begin
      w_elapsed[i] = Time - r_seatTs[i];
      w_release[i] = ((r_seatState[i] == ST_RESERVED) ||
                      (r_seatState[i] == ST_AWAY)) &&
                     (w_elapsed[i] >= TIMEOUT_MIN) &&
                     !(w_accept && (Seat_No == 5'(i)));
    end
  end
`else
  assign w_unusedBits = ^{Time, TIMEOUT[0], w_occupiedUnusedTag};
`endif

  // Build the records as they will look after this edge: auto-releases
  // first, then the accepted write on top. The free count is taken from
  // this same view so it moves together with the records.
  always_comb begin
    for (int i = 0; i < 32; i++) begin
      w_nextId[i]    = r_seatId[i];
      w_nextState[i] = r_seatState[i];
`ifdef SEAT_AUTO_RELEASE_EN
      w_nextTs[i]    = r_seatTs[i];
      if (w_release[i]) begin
        w_nextState[i] = ST_FREE;
        w_nextId[i]    = NULL_ID;
      end
`endif
    end

    if (w_accept) begin
      w_nextState[Seat_No] = Seat_State;
      w_nextId[Seat_No]    = (Seat_State == ST_FREE) ? NULL_ID : Student_No;
`ifdef SEAT_AUTO_RELEASE_EN
      w_nextTs[Seat_No]    = Time;
`endif
    end

    w_nextFree = 6'd0;
    for (int i = 0; i < 32; i++) begin
      if (w_nextState[i] == ST_FREE) begin
        w_nextFree = w_nextFree + 6'd1;
      end
    end
  end

  // Record storage and registered status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        r_seatId[i]    <= NULL_ID;
        r_seatState[i] <= ST_FREE;
`ifdef SEAT_AUTO_RELEASE_EN
        r_seatTs[i]    <= 11'd0;
`endif
      end
      free_count <= 6'd32;
      err        <= 1'b0;
`ifdef SEAT_AUTO_RELEASE_EN
      r_releaseEvt <= 1'b0;
`endif
    end else begin
      for (int i = 0; i < 32; i++) begin
        r_seatId[i]    <= w_nextId[i];
        r_seatState[i] <= w_nextState[i];
`ifdef SEAT_AUTO_RELEASE_EN
        r_seatTs[i]    <= w_nextTs[i];
`endif
      end
      free_count <= w_nextFree;
      err        <= w_reject;
`ifdef SEAT_AUTO_RELEASE_EN
      r_releaseEvt <= |w_release;
`endif
    end
  end

`ifdef SEAT_AUTO_RELEASE_EN
  assign release_evt = r_releaseEvt;
`else
  assign release_evt = 1'b0;
`endif

endmodule

// File: tb/tb_school_seating_system.sv
// ---------------------------------------------------------------------------
// tb_school_seating_system
//
// Purpose:
//   Self-checking bench for school_seating_system. A table of write/read
//   vectors exercises acceptance and rejection rules; short hand-built
//   sequences cover timeout expiry, time wrap, write-versus-release and
//   reset in the middle of operation. Expected values for each vector are
//   queued when the vector is driven and compared once the edge commits.
//
// Build option:
//   SEAT_AUTO_RELEASE_EN - selects the expected results for the auto-release
//   sequences so the bench matches whichever build is under test.
// ---------------------------------------------------------------------------
module tb_school_seating_system;

  localparam logic [24:0] NULL_ID = 25'h1FFFFFF;
  localparam logic [24:0] ID_A    = 25'h1EC10F3;

  logic        clk;
  logic        reset;
  logic [10:0] Time;
  logic [24:0] Student_No;
  logic [4:0]  Seat_No;
  logic        write;
  logic [1:0]  Seat_State;
  logic [24:0] rd_student;
  logic [1:0]  rd_state;
  logic [5:0]  free_count;
  logic        err;
  logic        release_evt;

  typedef struct {
    logic        wr;
    logic [4:0]  seat;
    logic [1:0]  st;
    logic [24:0] id;
    logic [10:0] tm;
    logic [1:0]  expState;
    logic [24:0] expId;
    logic [5:0]  expFree;
    logic        expErr;
    logic        expRel;
  } vec_t;

  vec_t  expQ [$];
  string tagQ [$];
  vec_t  tbl [13];

  int nVectors;
  int nChecks;
  int nMiscompares;

  school_seating_system #(.TIMEOUT(30)) dut (
    .clk        (clk),
    .reset      (reset),
    .Time       (Time),
    .Student_No (Student_No),
    .Seat_No    (Seat_No),
    .write      (write),
    .Seat_State (Seat_State),
    .rd_student (rd_student),
    .rd_state   (rd_state),
    .free_count (free_count),
    .err        (err),
    .release_evt(release_evt)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vec_t mk(input logic wr, input logic [4:0] seat,
                              input logic [1:0] st, input logic [24:0] id,
                              input logic [10:0] tm, input logic [1:0] eSt,
                              input logic [24:0] eId, input logic [5:0] eFree,
                              input logic eErr, input logic eRel);
    vec_t v;
    v.wr = wr; v.seat = seat; v.st = st; v.id = id; v.tm = tm;
    v.expState = eSt; v.expId = eId; v.expFree = eFree;
    v.expErr = eErr; v.expRel = eRel;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nMiscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Pops the oldest queued expectation and compares it with the DUT.
  task automatic checkOutput();
    vec_t  v;
    string t;
    if (expQ.size() == 0) begin
      nMiscompares++;
      $display("[TB] FAIL scoreboard: no expectation queued, got none expected one");
      return;
    end
    v = expQ.pop_front();
    t = tagQ.pop_front();
    check({t, ".rd_state"},    32'(rd_state),    32'(v.expState));
    check({t, ".rd_student"},  32'(rd_student),  32'(v.expId));
    check({t, ".free_count"},  32'(free_count),  32'(v.expFree));
    check({t, ".err"},         32'(err),         32'(v.expErr));
    check({t, ".release_evt"}, 32'(release_evt), 32'(v.expRel));
  endtask

  // Drives one vector between edges, queues its expectation, then checks
  // just after the edge that commits it.
  task automatic applyStimulus(input vec_t v, input string tag);
    @(negedge clk);
    write      = v.wr;
    Seat_No    = v.seat;
    Seat_State = v.st;
    Student_No = v.id;
    Time       = v.tm;
    expQ.push_back(v);
    tagQ.push_back(tag);
    nVectors++;
    @(posedge clk);
    #1;
    checkOutput();
    write = 1'b0;
  endtask

  // Asserts reset between edges while a write is being presented; the
  // outputs must clear at once and the write must be ignored.
  task automatic doReset(input string tag);
    @(negedge clk);
    reset      = 1'b1;
    write      = 1'b1;
    Seat_No    = 5'd10;
    Seat_State = 2'b10;
    Student_No = 25'h0000010;
    #1;
    check({tag, ".rst_free"},  32'(free_count),  32'd32);
    check({tag, ".rst_err"},   32'(err),         32'd0);
    check({tag, ".rst_rel"},   32'(release_evt), 32'd0);
    check({tag, ".rst_state"}, 32'(rd_state),    32'd0);
    @(posedge clk);
    #1;
    check({tag, ".rst_hold_state"}, 32'(rd_state),   32'd0);
    check({tag, ".rst_hold_id"},    32'(rd_student), 32'(NULL_ID));
    check({tag, ".rst_hold_free"},  32'(free_count), 32'd32);
    @(negedge clk);
    write = 1'b0;
    reset = 1'b0;
  endtask

  initial begin
    nVectors     = 0;
    nChecks      = 0;
    nMiscompares = 0;
    reset        = 1'b1;
    write        = 1'b0;
    Seat_No      = 5'd0;
    Seat_State   = 2'b00;
    Student_No   = NULL_ID;
    Time         = 11'd0;

    //          wr seat st     id             tm     eSt    eId          free  err  rel
    tbl[0]  = mk(1, 1,  2'b11, ID_A,         100, 2'b11, ID_A,         31, 0, 0);
    tbl[1]  = mk(1, 2,  2'b10, ID_A,         101, 2'b00, NULL_ID,      31, 1, 0);
    tbl[2]  = mk(0, 2,  2'b00, ID_A,         102, 2'b00, NULL_ID,      31, 0, 0);
    tbl[3]  = mk(1, 5,  2'b11, NULL_ID,      103, 2'b00, NULL_ID,      31, 1, 0);
    tbl[4]  = mk(0, 5,  2'b00, NULL_ID,      104, 2'b00, NULL_ID,      31, 0, 0);
    tbl[5]  = mk(1, 1,  2'b01, ID_A,         105, 2'b01, ID_A,         31, 0, 0);
    tbl[6]  = mk(1, 3,  2'b10, 25'h0000ABC,  106, 2'b10, 25'h0000ABC,  30, 0, 0);
    tbl[7]  = mk(1, 3,  2'b00, 25'h1234567,  107, 2'b00, NULL_ID,      31, 0, 0);
    tbl[8]  = mk(1, 4,  2'b01, 25'h0000ABC,  108, 2'b01, 25'h0000ABC,  30, 0, 0);
    tbl[9]  = mk(1, 31, 2'b10, 25'h0000001,  109, 2'b10, 25'h0000001,  29, 0, 0);
    tbl[10] = mk(1, 0,  2'b00, NULL_ID,      110, 2'b00, NULL_ID,      29, 0, 0);
    tbl[11] = mk(1, 31, 2'b11, 25'h0000001,  111, 2'b11, 25'h0000001,  29, 0, 0);
    tbl[12] = mk(1, 6,  2'b01, 25'h0000ABC,  112, 2'b00, NULL_ID,      29, 1, 0);

    doReset("init");
    for (int i = 0; i < 13; i++) begin
      applyStimulus(tbl[i], $sformatf("tbl%0d", i));
    end

    // Timeout expiry on an AWAY seat
    doReset("rst035");
    applyStimulus(mk(1, 1, 2'b11, ID_A, 100, 2'b11, ID_A, 31, 0, 0), "to.write");
    applyStimulus(mk(0, 1, 2'b00, ID_A, 129, 2'b11, ID_A, 31, 0, 0), "to.t129");
`ifdef SEAT_AUTO_RELEASE_EN
    applyStimulus(mk(0, 1, 2'b00, ID_A, 130, 2'b00, NULL_ID, 32, 0, 1), "to.t130");
    applyStimulus(mk(0, 1, 2'b00, ID_A, 131, 2'b00, NULL_ID, 32, 0, 0), "to.t131");
`else
    applyStimulus(mk(0, 1, 2'b00, ID_A, 130, 2'b11, ID_A, 31, 0, 0), "to.t130");
    applyStimulus(mk(0, 1, 2'b00, ID_A, 131, 2'b11, ID_A, 31, 0, 0), "to.t131");
`endif

    // A write on an expiring seat wins over the release
    doReset("rst024");
    applyStimulus(mk(1, 9, 2'b11, 25'h99, 500, 2'b11, 25'h99, 31, 0, 0), "ww.write");
    applyStimulus(mk(0, 9, 2'b00, 25'h99, 529, 2'b11, 25'h99, 31, 0, 0), "ww.t529");
    applyStimulus(mk(1, 9, 2'b01, 25'h99, 530, 2'b01, 25'h99, 31, 0, 0), "ww.t530");
    applyStimulus(mk(0, 9, 2'b00, 25'h99, 531, 2'b01, 25'h99, 31, 0, 0), "ww.t531");
`ifdef SEAT_AUTO_RELEASE_EN
    applyStimulus(mk(0, 9, 2'b00, 25'h99, 560, 2'b00, NULL_ID, 32, 0, 1), "ww.t560");
`else
    applyStimulus(mk(0, 9, 2'b00, 25'h99, 560, 2'b01, 25'h99, 31, 0, 0), "ww.t560");
`endif

    // Elapsed time across the 2048-minute wrap
    doReset("rst036");
    applyStimulus(mk(1, 3, 2'b01, 25'h777, 2040, 2'b01, 25'h777, 31, 0, 0), "wrap.write");
    applyStimulus(mk(0, 3, 2'b00, 25'h777, 20,   2'b01, 25'h777, 31, 0, 0), "wrap.t20");
    applyStimulus(mk(0, 3, 2'b00, 25'h777, 21,   2'b01, 25'h777, 31, 0, 0), "wrap.t21");
`ifdef SEAT_AUTO_RELEASE_EN
    applyStimulus(mk(0, 3, 2'b00, 25'h777, 22,   2'b00, NULL_ID, 32, 0, 1), "wrap.t22");
`else
    applyStimulus(mk(0, 3, 2'b00, 25'h777, 22,   2'b01, 25'h777, 31, 0, 0), "wrap.t22");
`endif

    // FREE write clears the ID, then reset in the middle of the sequence
    doReset("rst037a");
    applyStimulus(mk(1, 1, 2'b10, 25'h0ABCDEF, 50, 2'b10, 25'h0ABCDEF, 31, 0, 0), "fr.occ");
    applyStimulus(mk(1, 1, 2'b00, 25'h0ABCDEF, 51, 2'b00, NULL_ID,     32, 0, 0), "fr.free");
    applyStimulus(mk(1, 7, 2'b01, 25'h0000042, 52, 2'b01, 25'h0000042, 31, 0, 0), "fr.res7");
    doReset("rst037b");
    for (int s = 0; s < 32; s++) begin
      applyStimulus(mk(0, 5'(s), 2'b00, NULL_ID, 53, 2'b00, NULL_ID, 32, 0, 0),
                    $sformatf("scan%0d", s));
    end

    if (expQ.size() != 0) begin
      nMiscompares++;
      $display("[TB] FAIL scoreboard_drain: %0d left, expected 0", expQ.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
